// File: rtl/adpcm_pkg.sv
// Shared constants, types and the IMA step table for the ADPCM encoder tile.
package adpcm_pkg;

  typedef logic [6:0]  idx_t;
  typedef logic [14:0] step_t;

  // Byte-pairing state: which half of the 16-bit sample the next strobe carries.
  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  localparam idx_t IDX_MAX = 7'd88;

  // Saturation bounds at the width of the predictor update sum.
  localparam logic signed [17:0] PRED_MAX = 18'sd32767;
  localparam logic signed [17:0] PRED_MIN = -18'sd32768;

  // Step-index adjustment, indexed by the three magnitude bits of the code.
  localparam logic signed [7:0] ADJ [8] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

  // Standard 89-entry IMA step-size table.
  function automatic step_t step_of(input idx_t idx);
    case (idx)
      7'd0:  return 15'd7;     7'd1:  return 15'd8;     7'd2:  return 15'd9;
      7'd3:  return 15'd10;    7'd4:  return 15'd11;    7'd5:  return 15'd12;
      7'd6:  return 15'd13;    7'd7:  return 15'd14;    7'd8:  return 15'd16;
      7'd9:  return 15'd17;    7'd10: return 15'd19;    7'd11: return 15'd21;
      7'd12: return 15'd23;    7'd13: return 15'd25;    7'd14: return 15'd28;
      7'd15: return 15'd31;    7'd16: return 15'd34;    7'd17: return 15'd37;
      7'd18: return 15'd41;    7'd19: return 15'd45;    7'd20: return 15'd50;
      7'd21: return 15'd55;    7'd22: return 15'd60;    7'd23: return 15'd66;
      7'd24: return 15'd73;    7'd25: return 15'd80;    7'd26: return 15'd88;
      7'd27: return 15'd97;    7'd28: return 15'd107;   7'd29: return 15'd118;
      7'd30: return 15'd130;   7'd31: return 15'd143;   7'd32: return 15'd157;
      7'd33: return 15'd173;   7'd34: return 15'd190;   7'd35: return 15'd209;
      7'd36: return 15'd230;   7'd37: return 15'd253;   7'd38: return 15'd279;
      7'd39: return 15'd307;   7'd40: return 15'd337;   7'd41: return 15'd371;
      7'd42: return 15'd408;   7'd43: return 15'd449;   7'd44: return 15'd494;
      7'd45: return 15'd544;   7'd46: return 15'd598;   7'd47: return 15'd658;
      7'd48: return 15'd724;   7'd49: return 15'd796;   7'd50: return 15'd876;
      7'd51: return 15'd963;   7'd52: return 15'd1060;  7'd53: return 15'd1166;
      7'd54: return 15'd1282;  7'd55: return 15'd1411;  7'd56: return 15'd1552;
      7'd57: return 15'd1707;  7'd58: return 15'd1878;  7'd59: return 15'd2066;
      7'd60: return 15'd2272;  7'd61: return 15'd2499;  7'd62: return 15'd2749;
      7'd63: return 15'd3024;  7'd64: return 15'd3327;  7'd65: return 15'd3660;
      7'd66: return 15'd4026;  7'd67: return 15'd4428;  7'd68: return 15'd4871;
      7'd69: return 15'd5358;  7'd70: return 15'd5894;  7'd71: return 15'd6484;
      7'd72: return 15'd7132;  7'd73: return 15'd7845;  7'd74: return 15'd8630;
      7'd75: return 15'd9493;  7'd76: return 15'd10442; 7'd77: return 15'd11487;
      7'd78: return 15'd12635; 7'd79: return 15'd13899; 7'd80: return 15'd15289;
      7'd81: return 15'd16818; 7'd82: return 15'd18500; 7'd83: return 15'd20350;
      7'd84: return 15'd22385; 7'd85: return 15'd24623; 7'd86: return 15'd27086;
      7'd87: return 15'd29794; 7'd88: return 15'd32767;
      default: return 15'd32767;
    endcase
  endfunction

endpackage

// File: rtl/adpcm_if.sv
// Step-table lookup bus: the encoder presents an index, the ROM returns the step.
interface adpcm_if;
  import adpcm_pkg::*;

  idx_t  index;
  step_t step;

  modport master (output index, input step);
  modport slave  (input index, output step);
endinterface

// File: rtl/adpcm_step_rom.sv
// Combinational step-size ROM behind the lookup interface.
module adpcm_step_rom
  import adpcm_pkg::*;
(
  adpcm_if.slave bus
);

  // Pure table lookup, no state.
  always_comb bus.step = step_of(bus.index);

endmodule

// File: rtl/tt_um_adpcm_compressor.sv
// IMA/DVI ADPCM encoder tile: pairs two strobed bytes into a 16-bit sample
// and emits one 4-bit code per sample, keeping predictor and step index.
module tt_um_adpcm_compressor
  import adpcm_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic byte_stb;
  logic clear;
  logic unused_uio;

  assign byte_stb   = uio_in[0];
  assign clear      = uio_in[1];
  assign unused_uio = &{1'b0, uio_in[7:2]};

  // Architectural state.
  logic signed [15:0] pred;
  idx_t               index;
  logic [7:0]         lo;
  phase_e             phase;
  logic [3:0]         code;
  logic               code_valid;

  // Step lookup for the current index.
  adpcm_if step_bus ();
  assign step_bus.index = index;

  adpcm_step_rom u_step_rom (
    .bus (step_bus)
  );

  // Encoder datapath signals.
  logic signed [15:0] sample;
  logic signed [16:0] diff;
  logic               sign;
  logic [16:0]        mag;
  logic [16:0]        step17;
  logic [16:0]        rem;
  logic [16:0]        vp;
  logic [2:0]         c;
  logic signed [17:0] pred_ext;
  logic signed [17:0] vp_ext;
  logic signed [17:0] pred_sum;
  logic signed [15:0] pred_next;
  logic signed [7:0]  idx_sum;
  idx_t               index_next;

  // Difference against the predictor; 17 bits so full-scale swings never wrap.
  assign sample = {ui_in, lo};
  assign step17 = {2'b00, step_bus.step};
  assign diff   = {sample[15], sample} - {pred[15], pred};
  assign sign   = diff[16];
  assign mag    = sign ? -diff : diff;

  // Successive-approximation quantiser: three compare/subtract stages.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    rem = mag;
    vp  = step17 >> 3;
    c   = '0;
    if (rem >= step17) begin
      c[2] = 1'b1;
      rem  = rem - step17;
      vp   = vp + step17;
    end
    if (rem >= (step17 >> 1)) begin
      c[1] = 1'b1;
      rem  = rem - (step17 >> 1);
      vp   = vp + (step17 >> 1);
    end
    if (rem >= (step17 >> 2)) begin
      c[0] = 1'b1;
      vp   = vp + (step17 >> 2);
    end
  end

  // Predictor update with saturation to the 16-bit signed range.
  assign pred_ext = {{2{pred[15]}}, pred};
  assign vp_ext   = {1'b0, vp};
  assign pred_sum = sign ? (pred_ext - vp_ext) : (pred_ext + vp_ext);

  always_comb begin
    pred_next = pred_sum[15:0];
    if (pred_sum > PRED_MAX) begin
      pred_next = PRED_MAX[15:0];
    end else if (pred_sum < PRED_MIN) begin
      pred_next = PRED_MIN[15:0];
    end
  end

  // Step-index adaptation, clamped to the table range.
  assign idx_sum = $signed({1'b0, index}) + ADJ[c];

  always_comb begin
    index_next = idx_sum[6:0];
    if (idx_sum[7]) begin
      index_next = '0;
    end else if (idx_sum > $signed({1'b0, IDX_MAX})) begin
      index_next = IDX_MAX;
    end
  end

  // Byte pairing, clear and state commit; everything holds while ena is low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      pred       <= '0;
      index      <= '0;
      lo         <= '0;
      phase      <= PH_LO;
      code       <= '0;
      code_valid <= 1'b0;
    end else if (ena) begin
      code_valid <= 1'b0;
      if (clear) begin
        pred  <= '0;
        index <= '0;
        lo    <= '0;
        phase <= PH_LO;
        code  <= '0;
      end else if (byte_stb) begin
        if (phase == PH_LO) begin
          lo    <= ui_in;
          phase <= PH_HI;
        end else begin
          pred       <= pred_next;
          index      <= index_next;
          code       <= {sign, c};
          code_valid <= 1'b1;
          phase      <= PH_LO;
        end
      end
    end
  end

  assign uo_out  = {2'b00, phase, code_valid, code};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_adpcm_compressor.sv
// Scoreboard bench for the ADPCM encoder tile: stimulus pushes expected codes
// and predictor/index state, a negedge monitor pops on every code_valid.
module tb_tt_um_adpcm_compressor;
  import adpcm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_adpcm_compressor dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // Standalone step ROM, spot-checked against known table entries.
  adpcm_if rom_bus ();
  adpcm_step_rom u_rom_chk (
    .bus (rom_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model state and tables.
  int step_tbl [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int adj_tbl [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
  int m_pred = 0;
  int m_idx  = 0;

  typedef struct {
    logic [3:0] code;
    int         pred;
    int         index;
  } exp_t;

  exp_t sb [$];

  int n_valid      = 0;
  int trk_max_pred = -100000;
  int trk_min_pred = 100000;
  int trk_max_idx  = -1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model one encode and queue the expected response.
  task automatic push_expect(input int sample);
    exp_t e;
    int   diff, d, step, vp, np, ni;
    logic sgn;
    logic [2:0] cc;
    step = step_tbl[m_idx];
    diff = sample - m_pred;
    sgn  = (diff < 0);
    d    = sgn ? -diff : diff;
    cc   = 3'b000;
    vp   = step / 8;
    if (d >= step)     begin cc[2] = 1'b1; d = d - step;     vp = vp + step;     end
    if (d >= step / 2) begin cc[1] = 1'b1; d = d - step / 2; vp = vp + step / 2; end
    if (d >= step / 4) begin cc[0] = 1'b1;                   vp = vp + step / 4; end
    np = sgn ? m_pred - vp : m_pred + vp;
    if (np > 32767)  np = 32767;
    if (np < -32768) np = -32768;
    ni = m_idx + adj_tbl[cc];
    if (ni < 0)  ni = 0;
    if (ni > 88) ni = 88;
    m_pred  = np;
    m_idx   = ni;
    e.code  = {sgn, cc};
    e.pred  = np;
    e.index = ni;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    ui_in     = b;
    uio_in[0] = 1'b1;
    idle();
    uio_in[0] = 1'b0;
  endtask

  task automatic send_sample(input int sample);
    logic [15:0] s16;
    s16 = 16'(sample);
    push_expect(sample);
    put_byte(s16[7:0]);
    put_byte(s16[15:8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n  = 1'b1;
    m_pred = 0;
    m_idx  = 0;
  endtask

  task automatic reset_trackers();
    trk_max_pred = -100000;
    trk_min_pred = 100000;
    trk_max_idx  = -1;
  endtask

  // Monitor: pop and compare whenever the tile presents a code.
  always @(negedge clk) begin
    if (rst_n && uo_out[4]) begin
      exp_t e;
      n_valid++;
      check("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("code",  int'(uo_out[3:0]), int'(e.code));
        check("pred",  int'(dut.pred), e.pred);
        check("index", int'(dut.index), e.index);
        check("uio_oe",  int'(uio_oe), 0);
        check("uio_out", int'(uio_out), 0);
      end
      if (int'(dut.pred) > trk_max_pred) trk_max_pred = int'(dut.pred);
      if (int'(dut.pred) < trk_min_pred) trk_min_pred = int'(dut.pred);
      if (int'(dut.index) > trk_max_idx) trk_max_idx = int'(dut.index);
    end
  end

  initial begin
    int nv;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    check("reset_uo_out",  int'(uo_out), 8'h00);
    check("reset_uio_oe",  int'(uio_oe), 8'h00);
    check("reset_uio_out", int'(uio_out), 8'h00);

    // Step ROM spot values.
    rom_bus.index = 7'd0;  #1; check("rom_0",  int'(rom_bus.step), 7);
    rom_bus.index = 7'd9;  #1; check("rom_9",  int'(rom_bus.step), 17);
    rom_bus.index = 7'd44; #1; check("rom_44", int'(rom_bus.step), 494);
    rom_bus.index = 7'd88; #1; check("rom_88", int'(rom_bus.step), 32767);

    // Zero sample: code 0, one valid pulse, index clamped at 0.
    nv = n_valid;
    send_sample(0);
    idle();
    check("zero_valid_pulses", n_valid - nv, 1);
    check("zero_valid_low",    int'(uo_out[4]), 0);
    check("zero_code",         int'(uo_out[3:0]), 0);
    check("zero_pred",         int'(dut.pred), 0);
    check("zero_index",        int'(dut.index), 0);

    // Two samples of 100.
    do_reset();
    send_sample(100);
    idle();
    check("s100a_code",  int'(uo_out[3:0]), 4'h7);
    check("s100a_pred",  int'(dut.pred), 11);
    check("s100a_index", int'(dut.index), 8);
    send_sample(100);
    idle();
    check("s100b_code",  int'(uo_out[3:0]), 4'h7);
    check("s100b_pred",  int'(dut.pred), 41);
    check("s100b_index", int'(dut.index), 16);

    // Sample -100.
    do_reset();
    send_sample(-100);
    idle();
    check("sm100_code",  int'(uo_out[3:0]), 4'hF);
    check("sm100_pred",  int'(dut.pred), -11);
    check("sm100_index", int'(dut.index), 8);

    // Positive full scale, back to back: predictor pins at 32767.
    do_reset();
    reset_trackers();
    for (int i = 0; i < 200; i++) send_sample(32767);
    idle();
    check("pos_sat_pred",    int'(dut.pred), 32767);
    check("pos_sat_max",     trk_max_pred, 32767);
    check("pos_idx_bounded", int'(trk_max_idx <= 88), 1);

    // Alternating full scale drives the index into its upper clamp.
    for (int i = 0; i < 40; i++) send_sample((i % 2 == 0) ? -32768 : 32767);
    idle();
    check("alt_index_clamp", int'(dut.index), 88);

    // Negative full scale: predictor reaches but never passes -32768.
    reset_trackers();
    for (int i = 0; i < 50; i++) send_sample(-32768);
    idle();
    check("neg_sat_min", trk_min_pred, -32768);

    // Clear mid-sample discards the low byte and re-aligns.
    do_reset();
    put_byte(8'h11);
    check("mid_phase_hi", int'(uo_out[5]), 1);
    uio_in[1] = 1'b1;
    idle();
    uio_in[1] = 1'b0;
    m_pred = 0;
    m_idx  = 0;
    check("clear_uo_out", int'(uo_out), 8'h00);
    send_sample(100);
    idle();
    check("realign_code", int'(uo_out[3:0]), 4'h7);

    // Clear wins over a simultaneous strobe.
    ui_in  = 8'h55;
    uio_in = 8'h03;
    idle();
    uio_in = 8'h00;
    m_pred = 0;
    m_idx  = 0;
    check("clear_stb_uo_out", int'(uo_out), 8'h00);

    // ena low: strobes ignored in both phases.
    ena = 1'b0;
    put_byte(8'h64);
    check("ena0_phase_lo", int'(uo_out[5]), 0);
    check("ena0_valid_lo", int'(uo_out[4]), 0);
    ena = 1'b1;
    put_byte(8'h64);
    check("ena1_phase_hi", int'(uo_out[5]), 1);
    ena = 1'b0;
    nv  = n_valid;
    put_byte(8'h00);
    check("ena0_phase_hold", int'(uo_out[5]), 1);
    check("ena0_no_valid",   n_valid - nv, 0);
    ena = 1'b1;
    push_expect(100);
    put_byte(8'h00);
    idle();
    check("ena_resume_code", int'(uo_out[3:0]), 4'h7);
    check("ena_resume_pred", int'(dut.pred), 11);

    repeat (3) idle();
    check("sb_drained",    sb.size(), 0);
    check("final_uio_oe",  int'(uio_oe), 8'h00);
    check("final_uio_out", int'(uio_out), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
